mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum clk cycles to wait for each MFC edge before aborting (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 rwIn  input  1  request type: 1 = read, 0 = write.
REQ-006 addrIn  input  16  request address.
REQ-007 dataIn  input  16  write data.
REQ-008 MFC  input  1  memory function complete, from MEM.
REQ-009 memDataIn  input  16  read data, from MEM.
REQ-010 address  output  16  address to MEM, registered.
REQ-011 memDataOut  output  16  write data to MEM, registered.
REQ-012 R_W  output  1  to MEM: 1 = read, 0 = write, registered.
REQ-013 EN  output  1  MEM enable, registered.
REQ-014 dataOut  output  16  captured read data, registered.
REQ-015 busy  output  1  high from request acceptance until return to IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  timeout flag.

Function
REQ-018 States: IDLE, SETUP, ACCESS, RELEASE, DONE; encoding is free.
REQ-019 IDLE: at the edge where start=1, latch addrIn->address, dataIn->memDataOut and rwIn->R_W; clear err; set busy=1; go to SETUP.
REQ-020 start in any state other than IDLE is ignored; a request is never queued.
REQ-021 SETUP: EN=0 for exactly one cycle with address, data and R_W stable; go to ACCESS with EN=1.
REQ-022 ACCESS: EN=1. At the first edge with MFC=1: for a read, capture memDataIn into dataOut; drive EN=0; go to RELEASE.
REQ-023 Write requests SHALL leave dataOut unchanged.
REQ-024 RELEASE: EN=0. At the first edge with MFC=0, go to DONE. Handshake is four-phase: EN rises, MFC rises, EN falls, MFC falls.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE with busy=0.
REQ-026 address, memDataOut and R_W SHALL hold their values from acceptance until the next accepted request.
REQ-027 Timeout counter: 8-bit; cleared on each entry to ACCESS and to RELEASE; increments every cycle spent in those states.
REQ-028 On reaching TIMEOUT in ACCESS, set err=1, drive EN=0, skip data capture, and go to RELEASE.
REQ-029 On reaching TIMEOUT in RELEASE, set err=1 and go to DONE.
REQ-030 err SHALL remain high until the next accepted start.
REQ-031 If MFC and the timeout coincide on the same edge, MFC wins and err is not set.
REQ-032 If MFC is already 0 on entry to RELEASE, RELEASE lasts one cycle.
REQ-033 Minimum latency, read or write, with MFC responding immediately: start at edge E0; SETUP after E0; EN=1 after E1; MFC seen at E2; RELEASE after E2; MFC low seen at E3; done=1 after E3; IDLE after E4.
REQ-034 MFC=1 while in IDLE or SETUP SHALL have no effect.

Reset
REQ-035 reset=0 SHALL immediately, without a clock, force state to IDLE and drive all outputs to 0: address, memDataOut, dataOut=16'h0000; R_W, EN, busy, done, err=0; timeout counter 0.
REQ-036 Reset asserted mid-transaction SHALL abort the transaction; EN drops asynchronously and no done pulse is issued.
REQ-037 After reset release, the first start is accepted at the first rising edge where start=1.

Verification
REQ-038 Write: start, rwIn=0, addrIn=16'd7, dataIn=16'd15; MEM model asserts MFC 1 cycle after EN -> EN high exactly one SETUP cycle after acceptance, address=7, memDataOut=15, R_W=0, done pulses once, err=0, MEM[7]=15.
REQ-039 Read-back: start, rwIn=1, addrIn=7 after the write -> dataOut=16'd15 when done pulses; R_W=1 throughout.
REQ-040 Slow memory: MFC delayed 20 cycles with TIMEOUT=255 -> EN held 20+ cycles, normal completion, err=0.
REQ-041 Timeout: MFC never asserted with TIMEOUT=8 -> EN falls after 8 ACCESS cycles, err=1, dataOut unchanged, done pulses, err stays 1 until the next start.
REQ-042 start pulsed while busy, and MFC glitched in IDLE -> no new transaction, no state change, latched address unchanged.
REQ-043 reset=0 asserted while in ACCESS with EN=1 -> EN=0 and all outputs 0 before the next clk edge, no done pulse; a subsequent read of address 7 completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Bundles the request side and the memory side of mem_access_ctrl into one
// interface so the controller and its environment share a single port.
//
// Request side (from requester):
//   start      request strobe, sampled only while the controller is idle
//   rwIn       1 = read, 0 = write
//   addrIn     request address
//   dataIn     write data
// Memory side:
//   MFC        memory function complete (from MEM)
//   memDataIn  read data (from MEM)
//   address    address to MEM (registered)
//   memDataOut write data to MEM (registered)
//   R_W        1 = read, 0 = write (registered)
//   EN         MEM enable (registered)
// Status / result:
//   dataOut    captured read data
//   busy       high from request acceptance until back in IDLE
//   done       one-cycle completion pulse
//   err        timeout flag, held until the next accepted request
//
// Modports:
//   slave   - the controller itself
//   master  - the environment (requester plus memory)
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;

    logic        start;
    logic        rwIn;
    logic [15:0] addrIn;
    logic [15:0] dataIn;
    logic        MFC;
    logic [15:0] memDataIn;
    logic [15:0] address;
    logic [15:0] memDataOut;
    logic        R_W;
    logic        EN;
    logic [15:0] dataOut;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, rwIn, addrIn, dataIn, MFC, memDataIn,
        output address, memDataOut, R_W, EN, dataOut, busy, done, err
    );

    modport master (
        output start, rwIn, addrIn, dataIn, MFC, memDataIn,
        input  address, memDataOut, R_W, EN, dataOut, busy, done, err
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-request memory access controller using a four-phase handshake with
// the memory: EN rises, MFC rises, EN falls, MFC falls. A request is accepted
// in IDLE, the address/data/direction are registered, EN is held low for one
// setup cycle, then raised until MFC answers. Each wait for an MFC edge is
// bounded by TIMEOUT cycles; an expired wait sets err and the sequence
// continues to completion so the requester always sees a done pulse.
//
// Parameters:
//   TIMEOUT  cycles to wait for each MFC edge before giving up (1..255)
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset; aborts any transaction
//   bus      mem_access_ctrl_if.slave, request and memory signals
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // The counter is cleared on entry and compared before incrementing, so
    // the last allowed cycle is the one where it reads TIMEOUT-1. This gives
    // exactly TIMEOUT cycles in ACCESS (or RELEASE) before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state;
    logic [7:0] to_cnt;

    // NOTE: every register here is updated with non-blocking assignments so
    // all of them see the pre-edge values of each other, which is what keeps
    // the state and the registered outputs in step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            to_cnt         <= 8'd0;
            bus.address    <= 16'h0000;
            bus.memDataOut <= 16'h0000;
            bus.R_W        <= 1'b0;
            bus.EN         <= 1'b0;
            bus.dataOut    <= 16'h0000;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    // MFC is deliberately ignored here; only start matters.
                    if (bus.start) begin
                        bus.address    <= bus.addrIn;
                        bus.memDataOut <= bus.dataIn;
                        bus.R_W        <= bus.rwIn;
                        bus.err        <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    // One cycle with EN low so address/data/R_W are stable
                    // at the memory before the enable edge.
                    bus.EN <= 1'b1;
                    to_cnt <= 8'd0;
                    state  <= S_ACCESS;
                end

                S_ACCESS: begin
                    // MFC is tested first so an answer on the final allowed
                    // cycle completes normally instead of flagging err.
                    if (bus.MFC) begin
                        if (bus.R_W) begin
                            bus.dataOut <= bus.memDataIn;
                        end
                        bus.EN <= 1'b0;
                        to_cnt <= 8'd0;
                        state  <= S_RELEASE;
                    end else if (to_cnt == TO_LAST) begin
                        bus.err <= 1'b1;
                        bus.EN  <= 1'b0;
                        to_cnt  <= 8'd0;
                        state   <= S_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                S_RELEASE: begin
                    if (!bus.MFC) begin
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    to_cnt   <= 8'd0;
                    state    <= S_IDLE;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    bus.EN   <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    to_cnt   <= 8'd0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. dut_a (TIMEOUT=255) sits behind a small
// behavioural memory with programmable MFC delay; dut_b (TIMEOUT=8) has its
// MFC driven by hand to exercise timeout boundaries.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk;
    logic reset;

    mem_access_ctrl_if bus_a ();
    mem_access_ctrl_if bus_b ();

    mem_access_ctrl #(.TIMEOUT(255)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mem_access_ctrl #(.TIMEOUT(8))   dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model for dut_a ----------------
    logic [15:0] mem [0:255];
    logic        mfc_model;
    logic        mfc_force;
    logic        model_on;
    logic [15:0] mem_rdata;
    int          mfc_delay;
    int          en_seen;

    assign bus_a.MFC       = model_on ? mfc_model : mfc_force;
    assign bus_a.memDataIn = mem_rdata;

    initial begin
        mfc_model = 1'b0;
        mem_rdata = 16'h0000;
        en_seen   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset || !bus_a.EN) begin
                mfc_model = 1'b0;
                en_seen   = 0;
            end else if (!mfc_model) begin
                if (en_seen >= mfc_delay) begin
                    if (bus_a.R_W) mem_rdata = mem[bus_a.address[7:0]];
                    else           mem[bus_a.address[7:0]] = bus_a.memDataOut;
                    mfc_model = 1'b1;
                end else begin
                    en_seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a(input logic rw, input logic [15:0] addr, input logic [15:0] data);
        bus_a.rwIn   = rw;
        bus_a.addrIn = addr;
        bus_a.dataIn = data;
        bus_a.start  = 1'b1;
        tick();
        bus_a.start  = 1'b0;
    endtask

    // Runs dut_a until done is seen; reports latency from acceptance,
    // EN-high cycles and cycles where the latched address/R_W moved.
    task automatic wait_done_a(input int max_cycles, input logic [15:0] exp_addr,
                               input logic exp_rw, output int lat, output int en_cyc,
                               output int hold_bad, output bit seen);
        lat = 0; en_cyc = 0; hold_bad = 0; seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (bus_a.EN) en_cyc++;
            if (bus_a.address !== exp_addr || bus_a.R_W !== exp_rw) hold_bad++;
            if (bus_a.done) begin
                seen = 1'b1;
                lat  = i + 1;
                break;
            end
        end
    endtask

    // One transaction on dut_b. MFC rises after mfc_after EN-high
    // observations (0 = never) and falls once EN is low, unless hold_mfc.
    task automatic txn_b(input logic rw, input logic [15:0] addr, input logic [15:0] mdata,
                         input int mfc_after, input bit hold_mfc,
                         output int en_cyc, output bit seen, output logic err_acc);
        bus_b.rwIn      = rw;
        bus_b.addrIn    = addr;
        bus_b.dataIn    = 16'h0000;
        bus_b.memDataIn = mdata;
        bus_b.start     = 1'b1;
        tick();
        bus_b.start     = 1'b0;
        err_acc = bus_b.err;
        en_cyc  = 0;
        seen    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_b.done) begin
                seen = 1'b1;
                break;
            end
            if (bus_b.EN) begin
                en_cyc++;
                if (mfc_after != 0 && en_cyc == mfc_after) bus_b.MFC = 1'b1;
            end else if (!hold_mfc) begin
                bus_b.MFC = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        total++;
        if ({bus_a.address, bus_a.memDataOut, bus_a.dataOut, bus_a.R_W, bus_a.EN,
             bus_a.busy, bus_a.done, bus_a.err} !== 53'd0) begin
            bad++;
            $display("FAIL reset_a_outputs: got addr=%h wd=%h rd=%h rw=%b en=%b busy=%b done=%b err=%b, want all 0",
                     bus_a.address, bus_a.memDataOut, bus_a.dataOut, bus_a.R_W, bus_a.EN,
                     bus_a.busy, bus_a.done, bus_a.err);
        end
        total++;
        if ({bus_b.address, bus_b.memDataOut, bus_b.dataOut, bus_b.R_W, bus_b.EN,
             bus_b.busy, bus_b.done, bus_b.err} !== 53'd0) begin
            bad++;
            $display("FAIL reset_b_outputs: got nonzero outputs, want all 0");
        end
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_write();
        int lat, en_cyc, hold_bad;
        bit seen;
        accept_a(1'b0, 16'd7, 16'd15);
        total++;
        if ({bus_a.busy, bus_a.EN, bus_a.R_W} !== 3'b100 || bus_a.address !== 16'd7 || bus_a.memDataOut !== 16'd15) begin
            bad++;
            $display("FAIL write_accept: busy=%b en=%b rw=%b addr=%0d wd=%0d, want busy=1 en=0 rw=0 addr=7 wd=15",
                     bus_a.busy, bus_a.EN, bus_a.R_W, bus_a.address, bus_a.memDataOut);
        end
        wait_done_a(50, 16'd7, 1'b0, lat, en_cyc, hold_bad, seen);
        total++;
        if (!seen || lat != 3 || en_cyc != 1) begin
            bad++;
            $display("FAIL write_timing: seen=%b lat=%0d en_cycles=%0d, want seen=1 lat=3 en_cycles=1", seen, lat, en_cyc);
        end
        total++;
        if (hold_bad != 0 || bus_a.err !== 1'b0) begin
            bad++;
            $display("FAIL write_hold_err: hold_bad=%0d err=%b, want 0 and 0", hold_bad, bus_a.err);
        end
        total++;
        if (mem[7] !== 16'd15) begin
            bad++;
            $display("FAIL write_mem: mem[7]=%0d, want 15", mem[7]);
        end
        tick();
        total++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL write_end: done=%b busy=%b, want 0 0", bus_a.done, bus_a.busy);
        end
    endtask

    task automatic test_read_back();
        int lat, en_cyc, hold_bad;
        bit seen;
        accept_a(1'b1, 16'd7, 16'hAAAA);
        wait_done_a(50, 16'd7, 1'b1, lat, en_cyc, hold_bad, seen);
        total++;
        if (!seen || lat != 3 || hold_bad != 0) begin
            bad++;
            $display("FAIL read_timing: seen=%b lat=%0d hold_bad=%0d, want 1 3 0", seen, lat, hold_bad);
        end
        total++;
        if (bus_a.dataOut !== 16'd15 || bus_a.err !== 1'b0) begin
            bad++;
            $display("FAIL read_data: dataOut=%0d err=%b, want 15 0", bus_a.dataOut, bus_a.err);
        end
        tick();
    endtask

    task automatic test_slow_memory();
        int lat, en_cyc, hold_bad;
        bit seen;
        mfc_delay = 20;
        accept_a(1'b1, 16'd7, 16'h0000);
        wait_done_a(100, 16'd7, 1'b1, lat, en_cyc, hold_bad, seen);
        total++;
        if (!seen || en_cyc < 20 || bus_a.err !== 1'b0 || bus_a.dataOut !== 16'd15) begin
            bad++;
            $display("FAIL slow_mem: seen=%b en_cycles=%0d err=%b dataOut=%0d, want 1 >=20 0 15",
                     seen, en_cyc, bus_a.err, bus_a.dataOut);
        end
        mfc_delay = 0;
        tick();
    endtask

    task automatic test_ignore_while_busy();
        int lat, en_cyc, hold_bad, stray;
        bit seen;
        mfc_delay = 3;
        accept_a(1'b0, 16'h0042, 16'h0099);
        tick();
        bus_a.start  = 1'b1;
        bus_a.rwIn   = 1'b1;
        bus_a.addrIn = 16'h0BAD;
        bus_a.dataIn = 16'hFFFF;
        tick();
        bus_a.start  = 1'b0;
        wait_done_a(50, 16'h0042, 1'b0, lat, en_cyc, hold_bad, seen);
        total++;
        if (!seen || hold_bad != 0 || bus_a.memDataOut !== 16'h0099) begin
            bad++;
            $display("FAIL busy_start: seen=%b hold_bad=%0d wd=%h, want 1 0 0099", seen, hold_bad, bus_a.memDataOut);
        end
        // MFC glitch while idle: nothing may move.
        model_on  = 1'b0;
        mfc_force = 1'b1;
        stray     = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i > 0 && (bus_a.busy || bus_a.EN || bus_a.done || bus_a.address !== 16'h0042)) stray++;
        end
        mfc_force = 1'b0;
        model_on  = 1'b1;
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL idle_mfc_glitch: stray_cycles=%0d, want 0", stray);
        end
        mfc_delay = 0;
    endtask

    task automatic test_reset_mid();
        int lat, en_cyc, hold_bad;
        bit seen;
        mfc_delay = 10;
        accept_a(1'b1, 16'd7, 16'h0000);
        tick();
        tick();
        total++;
        if (bus_a.EN !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: EN=%b, want 1", bus_a.EN);
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({bus_a.address, bus_a.memDataOut, bus_a.dataOut, bus_a.R_W, bus_a.EN,
             bus_a.busy, bus_a.done, bus_a.err} !== 53'd0) begin
            bad++;
            $display("FAIL midreset_async: en=%b busy=%b addr=%h rd=%h, want all 0",
                     bus_a.EN, bus_a.busy, bus_a.address, bus_a.dataOut);
        end
        tick();
        total++;
        if (bus_a.done !== 1'b0 || bus_a.EN !== 1'b0) begin
            bad++;
            $display("FAIL midreset_nodone: done=%b en=%b, want 0 0", bus_a.done, bus_a.EN);
        end
        reset     = 1'b1;
        mfc_delay = 0;
        accept_a(1'b1, 16'd7, 16'h0000);
        wait_done_a(50, 16'd7, 1'b1, lat, en_cyc, hold_bad, seen);
        total++;
        if (!seen || lat != 3 || bus_a.dataOut !== 16'd15) begin
            bad++;
            $display("FAIL midreset_recover: seen=%b lat=%0d dataOut=%0d, want 1 3 15", seen, lat, bus_a.dataOut);
        end
        tick();
    endtask

    task automatic test_timeout();
        int en_cyc, stray;
        bit seen;
        logic err_acc;

        txn_b(1'b1, 16'd3, 16'h1234, 1, 1'b0, en_cyc, seen, err_acc);
        total++;
        if (!seen || en_cyc != 1 || bus_b.dataOut !== 16'h1234 || bus_b.err !== 1'b0) begin
            bad++;
            $display("FAIL tb_normal: seen=%b en=%0d dataOut=%h err=%b, want 1 1 1234 0",
                     seen, en_cyc, bus_b.dataOut, bus_b.err);
        end
        tick();

        bus_b.MFC = 1'b0;
        txn_b(1'b1, 16'd3, 16'hBEEF, 0, 1'b0, en_cyc, seen, err_acc);
        total++;
        if (!seen || en_cyc != 8 || bus_b.err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_access: seen=%b en_cycles=%0d err=%b, want 1 8 1", seen, en_cyc, bus_b.err);
        end
        total++;
        if (bus_b.dataOut !== 16'h1234) begin
            bad++;
            $display("FAIL timeout_data: dataOut=%h, want 1234", bus_b.dataOut);
        end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_b.err !== 1'b1) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL err_sticky: cycles_err_low=%0d, want 0", stray);
        end

        // MFC on the same edge as the last allowed cycle: MFC wins.
        txn_b(1'b1, 16'd4, 16'h5678, 8, 1'b0, en_cyc, seen, err_acc);
        total++;
        if (err_acc !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_on_start: err=%b after accept, want 0", err_acc);
        end
        total++;
        if (!seen || en_cyc != 8 || bus_b.err !== 1'b0 || bus_b.dataOut !== 16'h5678) begin
            bad++;
            $display("FAIL mfc_vs_timeout: seen=%b en=%0d err=%b dataOut=%h, want 1 8 0 5678",
                     seen, en_cyc, bus_b.err, bus_b.dataOut);
        end
        tick();

        // MFC stuck high after capture: RELEASE times out.
        txn_b(1'b1, 16'd5, 16'h4321, 1, 1'b1, en_cyc, seen, err_acc);
        total++;
        if (!seen || bus_b.err !== 1'b1 || bus_b.dataOut !== 16'h4321) begin
            bad++;
            $display("FAIL timeout_release: seen=%b err=%b dataOut=%h, want 1 1 4321",
                     seen, bus_b.err, bus_b.dataOut);
        end
        bus_b.MFC = 1'b0;
        tick();
    endtask

    initial begin
        model_on  = 1'b1;
        mfc_force = 1'b0;
        mfc_delay = 0;
        bus_a.start = 1'b0; bus_a.rwIn = 1'b0; bus_a.addrIn = 16'h0000; bus_a.dataIn = 16'h0000;
        bus_b.start = 1'b0; bus_b.rwIn = 1'b0; bus_b.addrIn = 16'h0000; bus_b.dataIn = 16'h0000;
        bus_b.MFC   = 1'b0; bus_b.memDataIn = 16'h0000;

        test_reset();
        test_write();
        test_read_back();
        test_slow_memory();
        test_ignore_while_busy();
        test_reset_mid();
        test_timeout();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
